// File: rtl/adc_pkg.sv
// Shared widths and the frame-length queue entry for the ADC frame buffer.
package adc_pkg;

    localparam int ADC_WORD_W = 32;
    localparam int ADC_LEN_W  = 8;

    typedef struct packed {
        logic [ADC_LEN_W-1:0] len;
    } fq_entry_t;

endpackage

// File: rtl/adc_sync_fifo_core.sv
// Single-clock pointer/memory FIFO with commit/rewind of the write pointer.
// Readers only see words below the commit pointer; tie i_commit high for a plain FIFO.
module adc_sync_fifo_core #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wen,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_commit,
    input  logic          i_rewind,
    input  logic          i_ren,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_nonempty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_wr_commit;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_nonempty;
    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_wr_commit_nxt;
    logic [AW:0]   w_rd_ptr_nxt;

    assign o_full     = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign o_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count    = r_count;
    assign o_nonempty = r_nonempty;

    // A rewind discards the open region, including any word written this cycle.
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr + {{AW{1'b0}}, i_wen};
        w_wr_commit_nxt = r_wr_commit;
        if (i_rewind)
            w_wr_ptr_nxt = r_wr_commit;
        else if (i_commit)
            w_wr_commit_nxt = w_wr_ptr_nxt;
        w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, i_ren};
    end

    always_ff @(posedge clk) begin
        if (i_wen)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_nonempty  <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_wr_commit_nxt - w_rd_ptr_nxt;
            r_nonempty  <= w_wr_commit_nxt != w_rd_ptr_nxt;
        end
    end

endmodule

// File: rtl/adc_frame_fifo.sv
// Frame-aware sample buffer: words are committed per frame on a flag rising edge,
// and only whole committed frames are released to the reader.
module adc_frame_fifo
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_WORD_W,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = ADC_LEN_W,
    parameter int FQ_AW      = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  adc_to_fifo_wen_hp,
    input  logic [DATA_WIDTH-1:0] adc_to_fifo_wdata,
    input  logic                  adc_frame_flag_h,
    input  logic                  rd_en_hp,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  frame_ready_h,
    output logic [LEN_WIDTH-1:0]  head_frame_len,
    output logic [FQ_AW:0]        frame_cnt,
    output logic [ADDR_WIDTH:0]   fill_words,
    output logic                  adc_fifo_module_frame_finish_flag_h,
    output logic                  ovf_err_h
);

    logic                  r_flag_p1;
    logic [LEN_WIDTH-1:0]  r_cur_len;
    logic                  r_bad;
    logic [LEN_WIDTH-1:0]  r_rd_cnt;
    logic                  r_finish;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_rd_data_p1;
    logic                  r_vld_p1;

    logic                  w_fedge;
    logic                  w_dat_full;
    logic                  w_dat_nonempty;
    logic [DATA_WIDTH-1:0] w_dat_head;
    logic                  w_wr_ok;
    logic [LEN_WIDTH-1:0]  w_len_nxt;
    logic                  w_bad_nxt;
    logic                  w_close;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_fq_full;
    fq_entry_t             w_fq_wdata;
    fq_entry_t             w_fq_head;
    logic [LEN_WIDTH-1:0]  w_head_len;
    logic [LEN_WIDTH-1:0]  w_rem;
    logic                  w_rd_ok;
    logic                  w_last;

    assign w_fedge = adc_frame_flag_h & ~r_flag_p1;

    // A write coinciding with the edge is counted into the frame being closed.
    assign w_wr_ok   = adc_to_fifo_wen_hp & ~w_dat_full & ~r_bad & (r_cur_len != '1);
    assign w_bad_nxt = r_bad | (adc_to_fifo_wen_hp & ~w_wr_ok);
    assign w_len_nxt = r_cur_len + LEN_WIDTH'(w_wr_ok);
    assign w_close   = w_fedge & (w_len_nxt != '0);
    assign w_drop    = w_close & (w_bad_nxt | w_fq_full);
    assign w_push    = w_close & ~w_drop;
    assign w_fq_wdata.len = ADC_LEN_W'(w_len_nxt);

    assign w_head_len = frame_ready_h ? LEN_WIDTH'(w_fq_head.len) : '0;
    assign w_rem      = w_head_len - r_rd_cnt;
    assign w_rd_ok    = rd_en_hp & frame_ready_h & w_dat_nonempty & (w_rem != '0);
    assign w_last     = w_rd_ok & (w_rem == LEN_WIDTH'(1));

    adc_sync_fifo_core #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_data (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_wen      (w_wr_ok),
        .i_wdata    (adc_to_fifo_wdata),
        .i_commit   (w_push),
        .i_rewind   (w_drop),
        .i_ren      (w_rd_ok),
        .o_head     (w_dat_head),
        .o_full     (w_dat_full),
        .o_count    (fill_words),
        .o_nonempty (w_dat_nonempty)
    );

    adc_sync_fifo_core #(
        .DW ($bits(fq_entry_t)),
        .AW (FQ_AW)
    ) u_fq (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_wen      (w_push),
        .i_wdata    (w_fq_wdata),
        .i_commit   (1'b1),
        .i_rewind   (1'b0),
        .i_ren      (w_last),
        .o_head     (w_fq_head),
        .o_full     (w_fq_full),
        .o_count    (frame_cnt),
        .o_nonempty (frame_ready_h)
    );

    // Stage p1: frame bookkeeping and registered read port.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_flag_p1    <= 1'b0;
            r_cur_len    <= '0;
            r_bad        <= 1'b0;
            r_rd_cnt     <= '0;
            r_finish     <= 1'b0;
            r_ovf        <= 1'b0;
            r_rd_data_p1 <= '0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_flag_p1 <= adc_frame_flag_h;
            if (w_fedge) begin
                r_cur_len <= '0;
                r_bad     <= 1'b0;
            end else begin
                r_cur_len <= w_len_nxt;
                r_bad     <= w_bad_nxt;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            if (w_last)
                r_rd_cnt <= '0;
            else if (w_rd_ok)
                r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
            if (w_last)
                r_finish <= 1'b1;
            else if (w_fedge)
                r_finish <= 1'b0;
            r_vld_p1 <= w_rd_ok;
            if (w_rd_ok)
                r_rd_data_p1 <= w_dat_head;
        end
    end

    assign rd_data        = r_rd_data_p1;
    assign rd_valid       = r_vld_p1;
    assign head_frame_len = w_head_len;
    assign adc_fifo_module_frame_finish_flag_h = r_finish;
    assign ovf_err_h      = r_ovf;

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Scoreboard bench for adc_frame_fifo: committed words are queued when written,
// and a negedge monitor pops and compares each rd_valid word.
module tb_adc_frame_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst = 1'b1;
    logic        wen     = 1'b0;
    logic [31:0] wdata   = '0;
    logic        flag    = 1'b0;
    logic        rd_en   = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        ready;
    logic [7:0]  head_len;
    logic [2:0]  frame_cnt;
    logic [9:0]  fill;
    logic        finish;
    logic        ovf;

    logic        s_wen   = 1'b0;
    logic [31:0] s_wdata = '0;
    logic        s_flag  = 1'b0;
    logic [31:0] s_rd_data;
    logic        s_rd_valid;
    logic        s_ready;
    logic [7:0]  s_head_len;
    logic [2:0]  s_frame_cnt;
    logic [4:0]  s_fill;
    logic        s_finish;
    logic        s_ovf;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    adc_frame_fifo dut (
        .sys_clk                             (clk),
        .sys_rst                             (sys_rst),
        .adc_to_fifo_wen_hp                  (wen),
        .adc_to_fifo_wdata                   (wdata),
        .adc_frame_flag_h                    (flag),
        .rd_en_hp                            (rd_en),
        .rd_data                             (rd_data),
        .rd_valid                            (rd_valid),
        .frame_ready_h                       (ready),
        .head_frame_len                      (head_len),
        .frame_cnt                           (frame_cnt),
        .fill_words                          (fill),
        .adc_fifo_module_frame_finish_flag_h (finish),
        .ovf_err_h                           (ovf)
    );

    adc_frame_fifo #(.ADDR_WIDTH(4)) dut_s (
        .sys_clk                             (clk),
        .sys_rst                             (sys_rst),
        .adc_to_fifo_wen_hp                  (s_wen),
        .adc_to_fifo_wdata                   (s_wdata),
        .adc_frame_flag_h                    (s_flag),
        .rd_en_hp                            (1'b0),
        .rd_data                             (s_rd_data),
        .rd_valid                            (s_rd_valid),
        .frame_ready_h                       (s_ready),
        .head_frame_len                      (s_head_len),
        .frame_cnt                           (s_frame_cnt),
        .fill_words                          (s_fill),
        .adc_fifo_module_frame_finish_flag_h (s_finish),
        .ovf_err_h                           (s_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input bit keep);
        wen   = 1'b1;
        wdata = d;
        if (keep) exp_q.push_back(d);
        step();
        wen = 1'b0;
    endtask

    task automatic close_frame();
        flag = 1'b1;
        step();
        flag = 1'b0;
        step();
    endtask

    task automatic frame(input logic [31:0] base, input int n, input bit keep);
        for (int i = 0; i < n; i++) put(base + 32'(i), keep);
        close_frame();
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_data"},   rd_data,   32'h0);
        check({tag, ".rd_valid"},  {31'h0, rd_valid},  32'h0);
        check({tag, ".ready"},     {31'h0, ready},     32'h0);
        check({tag, ".head_len"},  {24'h0, head_len},  32'h0);
        check({tag, ".frame_cnt"}, {29'h0, frame_cnt}, 32'h0);
        check({tag, ".fill"},      {22'h0, fill},      32'h0);
        check({tag, ".finish"},    {31'h0, finish},    32'h0);
        check({tag, ".ovf"},       {31'h0, ovf},       32'h0);
    endtask

    // Monitor: every valid read word must match the oldest committed expectation.
    always @(negedge clk) begin
        if (!sys_rst && rd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_data_unexpected: got 0x%0h, expected no valid word", rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        idle(2);
        sys_rst = 1'b0;
        check_all_zero("reset");

        // Read with nothing committed must be ignored.
        read_n(2);
        idle(1);
        check("empty_read.fill", {22'h0, fill}, 32'd0);

        // Basic 8-word frame.
        frame(32'h1, 8, 1'b1);
        check("basic.frame_cnt", {29'h0, frame_cnt}, 32'd1);
        check("basic.head_len",  {24'h0, head_len},  32'd8);
        check("basic.fill",      {22'h0, fill},      32'd8);
        check("basic.ready",     {31'h0, ready},     32'd1);
        read_n(7);
        check("basic.finish_early", {31'h0, finish}, 32'd0);
        read_n(1);
        check("basic.finish",    {31'h0, finish},    32'd1);
        check("basic.cnt_after", {29'h0, frame_cnt}, 32'd0);
        check("basic.ready_after", {31'h0, ready},   32'd0);
        idle(2);

        // Same-cycle close: the word on the edge belongs to the closing frame.
        put(32'h11, 1'b1);
        put(32'h22, 1'b1);
        put(32'h33, 1'b1);
        wen = 1'b1; wdata = 32'hAA; flag = 1'b1;
        exp_q.push_back(32'hAA);
        step();
        wen = 1'b0; flag = 1'b0;
        step();
        check("same.head_len", {24'h0, head_len}, 32'd4);
        check("same.finish_cleared", {31'h0, finish}, 32'd0);
        read_n(4);
        idle(2);
        check("same.drained", {22'h0, fill}, 32'd0);

        // Data overflow on the 16-word instance.
        for (int i = 0; i < 12; i++) begin
            s_wen = 1'b1; s_wdata = 32'h100 + 32'(i); step();
        end
        s_wen = 1'b0; s_flag = 1'b1; step(); s_flag = 1'b0; step();
        check("ovf.fill_first", {27'h0, s_fill}, 32'd12);
        for (int i = 0; i < 10; i++) begin
            s_wen = 1'b1; s_wdata = 32'h200 + 32'(i); step();
        end
        s_wen = 1'b0; s_flag = 1'b1; step(); s_flag = 1'b0; step();
        check("ovf.fill",      {27'h0, s_fill},      32'd12);
        check("ovf.err",       {31'h0, s_ovf},       32'd1);
        check("ovf.frame_cnt", {29'h0, s_frame_cnt}, 32'd1);
        check("ovf.head_len",  {24'h0, s_head_len},  32'd12);

        // Frame-queue full.
        frame(32'h300, 2, 1'b1);
        frame(32'h310, 2, 1'b1);
        frame(32'h320, 2, 1'b1);
        frame(32'h330, 2, 1'b1);
        check("qfull.cnt4", {29'h0, frame_cnt}, 32'd4);
        check("qfull.ovf_before", {31'h0, ovf}, 32'd0);
        frame(32'h340, 2, 1'b0);
        check("qfull.cnt", {29'h0, frame_cnt}, 32'd4);
        check("qfull.ovf", {31'h0, ovf},       32'd1);
        check("qfull.fill", {22'h0, fill},     32'd8);
        read_n(2);
        check("qfull.cnt_pop", {29'h0, frame_cnt}, 32'd3);
        check("qfull.finish",  {31'h0, finish},    32'd1);
        frame(32'h350, 2, 1'b1);
        check("qfull.cnt_refill", {29'h0, frame_cnt}, 32'd4);
        check("qfull.fill_refill", {22'h0, fill},     32'd8);
        read_n(8);
        idle(2);
        check("qfull.drained", {29'h0, frame_cnt}, 32'd0);

        // Length saturation with one committed frame already queued.
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        frame(32'h400, 3, 1'b1);
        frame(32'h500, 256, 1'b0);
        check("sat.ovf",       {31'h0, ovf},       32'd1);
        check("sat.fill",      {22'h0, fill},      32'd3);
        check("sat.frame_cnt", {29'h0, frame_cnt}, 32'd1);
        check("sat.head_len",  {24'h0, head_len},  32'd3);
        read_n(3);
        idle(2);
        check("sat.finish", {31'h0, finish}, 32'd1);

        // Reset mid-frame discards the open frame and all status.
        for (int i = 0; i < 5; i++) put(32'h600 + 32'(i), 1'b0);
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        check_all_zero("midrst");
        close_frame();
        check("midrst.edge_cnt", {29'h0, frame_cnt}, 32'd0);
        frame(32'h51, 2, 1'b1);
        check("midrst.new_len", {24'h0, head_len}, 32'd2);
        read_n(2);
        idle(3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
